// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM state type and IF/ID record for the fetch stage.
// The FETCH_ADEL_EN build also uses fetch_addr_fault() for the address check.
package fetch_unit_pkg;

    localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HOLD = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic        valid;
    } if_id_t;

    // limit is one past the last legal byte address, widened so base+size cannot wrap
    function automatic logic fetch_addr_fault(input logic [31:0] pc,
                                              input logic [31:0] base,
                                              input logic [32:0] limit);
        return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: stall/redirect inputs, instruction-memory port and IF/ID outputs.
// if_id_adel exists only when FETCH_ADEL_EN is defined.
interface fetch_unit_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
`ifdef FETCH_ADEL_EN
    logic        if_id_adel;
`endif

    // master: the fetch unit itself
    modport master (
        input  stall, redirect_valid, redirect_target, im_rdata,
        output im_addr, if_id_instr, if_id_pc, if_id_pc8, if_id_valid
`ifdef FETCH_ADEL_EN
        , output if_id_adel
`endif
    );

    // slave: hazard unit, ID next-PC logic and instruction memory
    modport slave (
        output stall, redirect_valid, redirect_target, im_rdata,
        input  im_addr, if_id_instr, if_id_pc, if_id_pc8, if_id_valid
`ifdef FETCH_ADEL_EN
        , input if_id_adel
`endif
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: loads when load=1, clears to a nop on reset.
// With FETCH_ADEL_EN the address-error flag travels alongside the record.
module fetch_unit_if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  if_id_t d,
`ifdef FETCH_ADEL_EN
    input  logic   adel_d,
    output logic   adel_q,
`endif
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '{instr: NOP_INSTR, pc: '0, pc8: '0, valid: 1'b0};
        end else if (load) begin
            q <= d;
        end
    end

`ifdef FETCH_ADEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            adel_q <= 1'b0;
        end else if (load) begin
            adel_q <= adel_d;
        end
    end
`endif

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, pending-redirect FSM and next-PC select.
// Optional FETCH_ADEL_EN adds the registered if_id_adel address-error flag.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_VAL,
    parameter int unsigned IM_WORDS = 4096
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  pending_target, pending_next;
    if_id_t       if_id_d, if_id_q;
    logic         fetch_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FETCH_RUN;
            pc             <= PC_RESET;
            pending_target <= '0;
        end else begin
            state          <= state_next;
            pc             <= pc_next;
            pending_target <= pending_next;
        end
    end

    // A redirect seen under stall is parked; the newest one wins, and a live
    // redirect in the release cycle overrides the parked target.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pending_next = pending_target;
        unique case (state)
            FETCH_RUN: begin
                if (!bus.stall) begin
                    pc_next = bus.redirect_valid ? bus.redirect_target : pc + 32'd4;
                end else if (bus.redirect_valid) begin
                    pending_next = bus.redirect_target;
                    state_next   = FETCH_HOLD;
                end
            end
            FETCH_HOLD: begin
                if (bus.stall) begin
                    if (bus.redirect_valid) begin
                        pending_next = bus.redirect_target;
                    end
                end else begin
                    pc_next    = bus.redirect_valid ? bus.redirect_target : pending_target;
                    state_next = FETCH_RUN;
                end
            end
            default: begin
                state_next = FETCH_RUN;
            end
        endcase
    end

`ifdef FETCH_ADEL_EN
    localparam logic [32:0] IM_LIMIT = {1'b0, PC_RESET} + {IM_WORDS[30:0], 2'b00};
    assign fetch_fault = fetch_addr_fault(pc, PC_RESET, IM_LIMIT);
`else
    assign fetch_fault = 1'b0;
`endif

    assign bus.im_addr = pc;

    always_comb begin
        if_id_d.instr = fetch_fault ? NOP_INSTR : bus.im_rdata;
        if_id_d.pc    = pc;
        if_id_d.pc8   = pc + 32'd8;
        if_id_d.valid = 1'b1;
    end

    fetch_unit_if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (~bus.stall),
        .d      (if_id_d),
`ifdef FETCH_ADEL_EN
        .adel_d (fetch_fault),
        .adel_q (bus.if_id_adel),
`endif
        .q      (if_id_q)
    );

    assign bus.if_id_instr = if_id_q.instr;
    assign bus.if_id_pc    = if_id_q.pc;
    assign bus.if_id_pc8   = if_id_q.pc8;
    assign bus.if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for the combinational-path, misaligned-redirect and wrap corners.
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit #(
        .PC_RESET (32'h0000_3000),
        .IM_WORDS (4096)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_adel;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic add(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt,
                       input logic [31:0] rdata, input logic [31:0] e_addr, input logic [31:0] e_pc,
                       input logic e_valid, input logic [31:0] e_instr, input logic e_adel);
        vec_t v;
        v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt; v.rdata = rdata;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_valid = e_valid; v.e_instr = e_instr; v.e_adel = e_adel;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic rv, input logic [31:0] tgt,
                         input logic [31:0] rdata);
        reset               = rst;
        bus.stall           = stl;
        bus.redirect_valid  = rv;
        bus.redirect_target = tgt;
        bus.im_rdata        = rdata;
    endtask

    // IF/ID check; pc8 tracks pc except in the cleared (invalid) state
    task automatic chk_state(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic e_valid, input logic [31:0] e_instr, input logic e_adel);
        logic [31:0] e_pc8;
        logic [31:0] e_ins;
        e_pc8 = e_valid ? e_pc + 32'd8 : 32'h0;
        e_ins = e_instr;
`ifdef FETCH_ADEL_EN
        if (e_adel) e_ins = 32'h0;
        chk({tag, " if_id_adel"}, {31'h0, bus.if_id_adel}, {31'h0, e_adel});
`else
        if (e_adel) e_ins = e_instr;
`endif
        chk({tag, " im_addr"},     bus.im_addr,                 e_addr);
        chk({tag, " if_id_pc"},    bus.if_id_pc,                e_pc);
        chk({tag, " if_id_pc8"},   bus.if_id_pc8,               e_pc8);
        chk({tag, " if_id_valid"}, {31'h0, bus.if_id_valid},    {31'h0, e_valid});
        chk({tag, " if_id_instr"}, bus.if_id_instr,             e_ins);
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        //   rst   stl   rv    tgt            rdata          e_addr         e_pc           vld   e_instr        adel
        add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_3000, 32'h0,         1'b0, 32'h0,         1'b0);
        add(1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0,         1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h2408_0001, 32'h0000_3004, 32'h0000_3000, 1'b1, 32'h2408_0001, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h2408_0001, 32'h0000_3008, 32'h0000_3004, 1'b1, 32'h2408_0001, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h2408_0001, 32'h0000_300C, 32'h0000_3008, 1'b1, 32'h2408_0001, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_3000, 32'h0,         1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h11,        32'h0000_3004, 32'h0000_3000, 1'b1, 32'h11,        1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'h12,        32'h0000_3100, 32'h0000_3004, 1'b1, 32'h12,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h22,        32'h0000_3104, 32'h0000_3100, 1'b1, 32'h22,        1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_3200, 32'h33,        32'h0000_3104, 32'h0000_3100, 1'b1, 32'h22,        1'b0);
        add(1'b0, 1'b1, 1'b0, 32'h0,         32'h33,        32'h0000_3104, 32'h0000_3100, 1'b1, 32'h22,        1'b0);
        add(1'b0, 1'b1, 1'b0, 32'h0,         32'h33,        32'h0000_3104, 32'h0000_3100, 1'b1, 32'h22,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h44,        32'h0000_3200, 32'h0000_3104, 1'b1, 32'h44,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h55,        32'h0000_3204, 32'h0000_3200, 1'b1, 32'h55,        1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_3200, 32'h66,        32'h0000_3204, 32'h0000_3200, 1'b1, 32'h55,        1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_3300, 32'h66,        32'h0000_3204, 32'h0000_3200, 1'b1, 32'h55,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h66,        32'h0000_3300, 32'h0000_3204, 1'b1, 32'h66,        1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_3500, 32'h77,        32'h0000_3300, 32'h0000_3204, 1'b1, 32'h66,        1'b0);
        add(1'b0, 1'b0, 1'b1, 32'h0000_3400, 32'h77,        32'h0000_3400, 32'h0000_3300, 1'b1, 32'h77,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h88,        32'h0000_3404, 32'h0000_3400, 1'b1, 32'h88,        1'b0);
        add(1'b0, 1'b1, 1'b1, 32'h0000_3200, 32'h99,        32'h0000_3404, 32'h0000_3400, 1'b1, 32'h88,        1'b0);
        add(1'b1, 1'b1, 1'b0, 32'h0,         32'h99,        32'h0000_3000, 32'h0,         1'b0, 32'h0,         1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'h99,        32'h0000_3004, 32'h0000_3000, 1'b1, 32'h99,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'hA1,        32'h0000_3008, 32'h0000_3004, 1'b1, 32'hA1,        1'b0);
        add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hAA,        32'hFFFF_FFFC, 32'h0000_3008, 1'b1, 32'hAA,        1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0,         32'hBB,        32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 32'hBB,        1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt, vecs[i].rdata);
            @(posedge clk);
            #1;
            chk_state($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_pc, vecs[i].e_valid,
                      vecs[i].e_instr, vecs[i].e_adel);
        end

        // redirect and stall must not reach im_addr before the edge
        drive(1'b0, 1'b1, 1'b1, 32'h0000_3102, 32'hCC);
        #1;
        chk("comb stall+redirect im_addr", bus.im_addr, 32'h0);
        bus.stall = 1'b0;
        #1;
        chk("comb redirect im_addr", bus.im_addr, 32'h0);
        @(posedge clk);
        #1;
        chk_state("h0", 32'h0000_3102, 32'h0, 1'b1, 32'hCC, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hDD);
        @(posedge clk);
        #1;
        chk_state("h1", 32'h0000_3106, 32'h0000_3102, 1'b1, 32'hDD, 1'b1);

        drive(1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'hEE);
        @(posedge clk);
        #1;
        chk_state("h2", 32'h0000_3000, 32'h0000_3106, 1'b1, 32'hEE, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hFF);
        @(posedge clk);
        #1;
        chk_state("h3", 32'h0000_3004, 32'h0000_3000, 1'b1, 32'hFF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the PC register, drives the instruction-memory address and loads the IF/ID pipeline register.
- Consumes redirect targets produced by next-PC logic in ID (branch/jump, delay-slot semantics) and stall requests from the hazard unit.
- A redirect pulse arriving during a stall is captured and applied once the stall clears.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- IM_WORDS, 4096, instruction-memory depth in words; used only by the optional address check.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes PC and IF/ID.
- redirect_valid  input  1  single-cycle pulse: branch taken / jump resolved in ID.
- redirect_target  input  32  next PC when redirect_valid=1.
- im_addr  output  32  instruction-memory read address (= current PC, combinational).
- im_rdata  input  32  instruction word at im_addr (combinational read).
- if_id_instr  output  32  registered instruction for ID.
- if_id_pc  output  32  registered PC of that instruction.
- if_id_pc8  output  32  if_id_pc + 8; link address for jal/jalr.
- if_id_valid  output  1  IF/ID holds a real fetched instruction.

Behaviour:
- Reset (clk edge with reset=1), overriding all other inputs:
  - pc=PC_RESET; if_id_instr=0 (nop); if_id_pc=0; if_id_pc8=0; if_id_valid=0.
  - pending_target=0; state=RUN.
- State machine, 1 bit:
  - RUN: no saved redirect.
  - HOLD: a redirect arrived while stalled and is held in pending_target.
- RUN, stall=0:
  - IF/ID <= {im_rdata, pc, pc+8}; if_id_valid <= 1.
  - pc <= redirect_valid ? redirect_target : pc+4.
- RUN, stall=1:
  - pc and IF/ID hold.
  - If redirect_valid=1: pending_target <= redirect_target; go to HOLD.
- HOLD, stall=1:
  - pc and IF/ID hold.
  - A new redirect_valid overwrites pending_target (newest wins).
- HOLD, stall=0:
  - IF/ID loads as in RUN.
  - pc <= redirect_valid ? redirect_target : pending_target.
  - Go to RUN.
- Delay slot: a redirect never flushes IF/ID. The instruction fetched in the redirect cycle (the delay slot) enters ID normally.
- Latency: a redirect in cycle N (no stall) makes im_addr = target in cycle N+1.
- Arithmetic: pc+4 and pc+8 are modulo 2^32; 32'hFFFF_FFFC wraps to 0. No alignment correction is applied; redirect_target is taken verbatim.
- im_addr is a pure function of pc; no combinational path from redirect_valid or stall to im_addr.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - Extra output if_id_adel (1 bit, reset 0), registered alongside IF/ID.
  - Set when the fetched pc has pc[1:0]!=0, or lies outside [PC_RESET, PC_RESET+4*IM_WORDS).
  - When set, if_id_instr is forced to 0 (nop) instead of im_rdata; if_id_pc still holds the faulting pc.
- Undefined: port absent; no address checking; im_rdata is always forwarded.

Decomposition:
- constants.v gets:
  - `PC_RESET_VAL (32'h0000_3000)
  - `NOP_INSTR (32'h0)
  - state encodings `fetchRun=1'b0, `fetchHold=1'b1
- Natural sub-module: if_id_reg.
  - Loads on ~stall; clears on reset.
  - Holds instr/pc/pc8/valid (and adel when enabled).
- fetch_unit keeps the PC register, the pending-redirect FSM and the next-PC selection.

Test Plan:
1. reset=1 for 2 cycles, then 0 → im_addr=32'h3000; if_id_valid=0; if_id_instr=0 until the first post-reset edge.
2. Free run from reset, im_rdata=32'h2408_0001 → after 3 edges im_addr=32'h300C, if_id_pc=32'h3008, if_id_pc8=32'h3010, if_id_valid=1.
3. Redirect pulse at pc=32'h3004 to 32'h3100, no stall → next cycle im_addr=32'h3100; if_id_pc=32'h3004 (delay slot kept).
4. stall=1 for 3 cycles with redirect pulse 32'h3200 in the first stalled cycle → im_addr frozen during the stall; one cycle after stall drops im_addr=32'h3200.
5. Pulses 32'h3200 then 32'h3300 in consecutive stalled cycles, then release → pc=32'h3300. Variant: a redirect to 32'h3400 in the release cycle → pc=32'h3400.
6. Reset asserted while in HOLD with pending 32'h3200 → pc=32'h3000; after release, sequential fetch with no stray jump to 32'h3200. With FETCH_ADEL_EN defined, redirect to 32'h3102 → if_id_adel=1, if_id_instr=0.
